// File: rtl/packet_readout_sequencer.sv
// Reads one packet out of the receive buffer and forwards it as a first/last-marked byte stream.
// Define PACKET_READOUT_FAULT_FORWARD_EN to stream faulted packets with StreamError on the last byte.
module packet_readout_sequencer #(
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned TRIM       = 1,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             SysClock,
    input  logic             ResetN,
    input  logic             Enable,
    input  logic             PacketReady,
    input  logic             PacketFault,
    input  logic [11:0]      PacketSize,
    output logic [10:0]      BufAddress,
    input  logic [7:0]       BufData,
    output logic             ReadEna,
    output logic [7:0]       StreamData,
    output logic             StreamValid,
    input  logic             StreamReady,
    output logic             StreamFirst,
    output logic             StreamLast,
`ifdef PACKET_READOUT_FAULT_FORWARD_EN
    output logic             StreamError,
`endif
    output logic [CNT_W-1:0] PacketCount,
    output logic [CNT_W-1:0] FaultCount,
    output logic [CNT_W-1:0] DropCount,
    output logic             Busy
);

    localparam int unsigned Depth = RD_LATENCY + 2;
    localparam int unsigned PtrW  = $clog2(Depth);
    localparam int unsigned OccW  = $clog2(Depth + 1);
    localparam logic [PtrW-1:0] LastSlot = PtrW'(Depth - 1);
    localparam logic [11:0] TrimW = 12'(TRIM);
`ifdef PACKET_READOUT_FAULT_FORWARD_EN
    localparam bit FwdFaults = 1'b1;
`else
    localparam bit FwdFaults = 1'b0;
`endif

    typedef enum logic [2:0] {StIdle, StLoad, StRead, StDrain, StRelease, StHoldoff} seqState;

    seqState stateQ, stateD;
    logic [11:0] lenQ, lenD, ptrQ, ptrD, outIdxQ, outIdxD;
    logic faultQ, faultD;
    logic [RD_LATENCY-1:0] pipeQ, pipeD;
    logic [7:0] fifoMem [Depth];
    logic [PtrW-1:0] wrPtrQ, rdPtrQ;
    logic [OccW-1:0] countQ;
    logic [11:0] stored, lenCalc;
    logic [3:0] inFlight;
    logic issue, push, pop, faultInc, dropInc, packetInc;

    always_comb begin
        stored = PacketSize >> 1;
        if (stored > 12'd2048) stored = 12'd2048;
        lenCalc = (stored > TrimW) ? stored - TrimW : '0;
    end

    // Credit: reads in flight plus queued bytes never exceed the FIFO depth.
    always_comb begin
        inFlight = 4'(countQ);
        for (int i = 0; i < RD_LATENCY; i++) inFlight = inFlight + 4'(pipeQ[i]);
    end

    always_comb begin
        stateD   = stateQ;
        lenD     = lenQ;
        faultD   = faultQ;
        ptrD     = ptrQ;
        issue    = 1'b0;
        faultInc = 1'b0;
        dropInc  = 1'b0;
        case (stateQ)
            StIdle: if (Enable && (PacketReady || PacketFault)) stateD = StLoad;
            StLoad: begin
                lenD     = lenCalc;
                faultD   = PacketFault;
                ptrD     = '0;
                faultInc = PacketFault;
                if (lenCalc != '0 && (!PacketFault || FwdFaults)) begin
                    stateD = StRead;
                end else begin
                    dropInc = 1'b1;
                    stateD  = StRelease;
                end
            end
            StRead: begin
                if (inFlight < 4'(Depth)) begin
                    issue = 1'b1;
                    ptrD  = ptrQ + 12'd1;
                    if (ptrQ + 12'd1 == lenQ) stateD = StDrain;
                end
            end
            StDrain: if (pipeQ == '0 && countQ == '0) stateD = StRelease;
            StRelease: stateD = StHoldoff;
            StHoldoff: if (!PacketReady && !PacketFault) stateD = StIdle;
            default: stateD = StIdle;
        endcase
    end

    always_comb begin
        pipeD[0] = issue;
        for (int i = 1; i < RD_LATENCY; i++) pipeD[i] = pipeQ[i-1];
    end

    assign push        = pipeQ[RD_LATENCY-1];
    assign StreamValid = countQ != '0;
    assign pop         = StreamValid && StreamReady;
    assign StreamData  = StreamValid ? fifoMem[rdPtrQ] : 8'h00;
    assign StreamFirst = StreamValid && (outIdxQ == 12'd0);
    assign StreamLast  = StreamValid && (outIdxQ == lenQ - 12'd1);
`ifdef PACKET_READOUT_FAULT_FORWARD_EN
    assign StreamError = StreamLast && faultQ;
`endif
    assign packetInc   = pop && StreamLast && !faultQ;
    assign outIdxD     = (stateQ == StLoad) ? 12'd0 : (pop ? outIdxQ + 12'd1 : outIdxQ);
    assign BufAddress  = ptrQ[10:0];
    assign ReadEna     = stateQ == StRelease;
    assign Busy        = stateQ != StIdle;

    always_ff @(posedge SysClock or negedge ResetN) begin
        if (!ResetN) begin
            stateQ      <= StIdle;
            lenQ        <= '0;
            faultQ      <= 1'b0;
            ptrQ        <= '0;
            outIdxQ     <= '0;
            pipeQ       <= '0;
            wrPtrQ      <= '0;
            rdPtrQ      <= '0;
            countQ      <= '0;
            PacketCount <= '0;
            FaultCount  <= '0;
            DropCount   <= '0;
        end else begin
            stateQ  <= stateD;
            lenQ    <= lenD;
            faultQ  <= faultD;
            ptrQ    <= ptrD;
            outIdxQ <= outIdxD;
            pipeQ   <= pipeD;
            if (push) wrPtrQ <= (wrPtrQ == LastSlot) ? '0 : wrPtrQ + 1'b1;
            if (pop) rdPtrQ <= (rdPtrQ == LastSlot) ? '0 : rdPtrQ + 1'b1;
            if (push && !pop) countQ <= countQ + 1'b1;
            else if (!push && pop) countQ <= countQ - 1'b1;
            if (packetInc) PacketCount <= PacketCount + 1'b1;
            if (faultInc) FaultCount <= FaultCount + 1'b1;
            if (dropInc) DropCount <= DropCount + 1'b1;
        end
    end

    always_ff @(posedge SysClock) begin
        if (push) fifoMem[wrPtrQ] <= BufData;
    end

endmodule

// File: tb/tb_packet_readout_sequencer.sv
// Randomized scoreboard bench for packet_readout_sequencer with a behavioural buffer model.
// Honours PACKET_READOUT_FAULT_FORWARD_EN when defined.
module tb_packet_readout_sequencer;
    localparam int unsigned RdLat = 3;
    localparam int unsigned Trim  = 1;
    localparam int unsigned CntW  = 16;
`ifdef PACKET_READOUT_FAULT_FORWARD_EN
    localparam bit Fwd = 1'b1;
`else
    localparam bit Fwd = 1'b0;
`endif

    logic SysClock, ResetN, Enable, PacketReady, PacketFault;
    logic [11:0] PacketSize;
    logic [10:0] BufAddress;
    logic [7:0] BufData, StreamData;
    logic ReadEna, StreamValid, StreamReady, StreamFirst, StreamLast, Busy;
    logic [CntW-1:0] PacketCount, FaultCount, DropCount;
`ifdef PACKET_READOUT_FAULT_FORWARD_EN
    logic StreamError;
`endif

    packet_readout_sequencer #(.RD_LATENCY(RdLat), .TRIM(Trim), .CNT_W(CntW)) dut (
        .SysClock(SysClock), .ResetN(ResetN), .Enable(Enable),
        .PacketReady(PacketReady), .PacketFault(PacketFault), .PacketSize(PacketSize),
        .BufAddress(BufAddress), .BufData(BufData), .ReadEna(ReadEna),
        .StreamData(StreamData), .StreamValid(StreamValid), .StreamReady(StreamReady),
        .StreamFirst(StreamFirst), .StreamLast(StreamLast),
`ifdef PACKET_READOUT_FAULT_FORWARD_EN
        .StreamError(StreamError),
`endif
        .PacketCount(PacketCount), .FaultCount(FaultCount), .DropCount(DropCount),
        .Busy(Busy)
    );

    initial SysClock = 1'b0;
    always #5 SysClock = ~SysClock;

    // Buffer: synchronous read with RdLat cycles from address to data.
    logic [7:0] mem [2048];
    logic [7:0] rdPipe [RdLat];
    always @(posedge SysClock) begin
        rdPipe[0] <= mem[BufAddress];
        for (int i = 1; i < RdLat; i++) rdPipe[i] <= rdPipe[i-1];
    end
    assign BufData = rdPipe[RdLat-1];

    typedef struct {
        logic [7:0] data;
        bit first;
        bit last;
        bit err;
    } beat_t;
    beat_t expQ[$];

    int nVec = 0, nFail = 0;
    int pktCnt = 0, fltCnt = 0, drpCnt = 0;
    int readyMode = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        nVec++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Sink ready pattern, changed just after the rising edge.
    initial begin
        int phase;
        phase = 0;
        StreamReady = 1'b1;
        forever begin
            @(posedge SysClock);
            #1;
            case (readyMode)
                0: StreamReady = 1'b1;
                1: begin
                    StreamReady = (phase == 0);
                    phase = (phase + 1) % 3;
                end
                default: StreamReady = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: pops the scoreboard on every accepted byte and checks stall stability.
    initial begin
        logic prevStall;
        logic [9:0] prevHeld;
        beat_t b;
        prevStall = 1'b0;
        prevHeld = '0;
        forever begin
            @(negedge SysClock);
            if (!ResetN) begin
                prevStall = 1'b0;
            end else begin
                if (prevStall) begin
                    chk("stall_valid", StreamValid, 1);
                    chk("stall_hold", {StreamData, StreamFirst, StreamLast}, prevHeld);
                end
                if (StreamValid && StreamReady) begin
                    if (expQ.size() == 0) begin
                        chk("extra_byte", StreamData, -1);
                    end else begin
                        b = expQ.pop_front();
                        chk("byte_data", StreamData, b.data);
                        chk("byte_first", StreamFirst, b.first);
                        chk("byte_last", StreamLast, b.last);
`ifdef PACKET_READOUT_FAULT_FORWARD_EN
                        chk("byte_error", StreamError, b.err);
`endif
                    end
                end
                if (ReadEna) chk("release_after_drain", expQ.size(), 0);
                prevStall = StreamValid && !StreamReady;
                prevHeld = {StreamData, StreamFirst, StreamLast};
            end
        end
    end

    function automatic int model_len(input int size);
        int stored;
        stored = size / 2;
        if (stored > 2048) stored = 2048;
        return (stored > Trim) ? stored - Trim : 0;
    endfunction

    task automatic load_packet(input int size, input bit fault);
        int len;
        bit fwd;
        beat_t b;
        for (int a = 0; a < 2048; a++) mem[a] = 8'($urandom);
        len = model_len(size);
        fwd = (len > 0) && (!fault || Fwd);
        if (fwd) begin
            for (int i = 0; i < len; i++) begin
                b.data = mem[i];
                b.first = (i == 0);
                b.last = (i == len - 1);
                b.err = fault && (i == len - 1);
                expQ.push_back(b);
            end
        end
        if (fault) fltCnt++;
        if (!fwd) drpCnt++;
        else if (!fault) pktCnt++;
    endtask

    task automatic run_packet(input int size, input bit fault, input bit good,
                              input int holdExtra, input int mode);
        int n;
        readyMode = mode;
        load_packet(size, fault);
        PacketSize = 12'(size);
        PacketReady = good;
        PacketFault = fault;
        n = 0;
        do begin
            @(negedge SysClock);
            n++;
        end while (!ReadEna && n < 20000);
        if (!ReadEna) begin
            chk("readena_timeout", 0, 1);
            expQ.delete();
        end else begin
            @(negedge SysClock);
            chk("readena_width", ReadEna, 0);
            for (int i = 0; i < holdExtra; i++) begin
                chk("holdoff_busy", Busy, 1);
                chk("holdoff_no_rerelease", ReadEna, 0);
                @(negedge SysClock);
            end
        end
        PacketReady = 1'b0;
        PacketFault = 1'b0;
        repeat (2) @(negedge SysClock);
        chk("idle_after_release", Busy, 0);
        chk("all_bytes_seen", expQ.size(), 0);
        chk("packet_count", PacketCount, pktCnt % 65536);
        chk("fault_count", FaultCount, fltCnt % 65536);
        chk("drop_count", DropCount, drpCnt % 65536);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"}, StreamValid, 0);
        chk({tag, "_readena"}, ReadEna, 0);
        chk({tag, "_busy"}, Busy, 0);
        chk({tag, "_addr"}, BufAddress, 0);
        chk({tag, "_data"}, StreamData, 0);
        chk({tag, "_firstlast"}, {StreamFirst, StreamLast}, 0);
        chk({tag, "_counts"}, {PacketCount, FaultCount, DropCount}, 0);
    endtask

    task automatic reset_mid_read();
        readyMode = 0;
        load_packet(400, 1'b0);
        PacketSize = 12'd400;
        PacketReady = 1'b1;
        repeat (60) @(negedge SysClock);
        chk("busy_before_reset", Busy, 1);
        @(posedge SysClock);
        #2;
        ResetN = 1'b0;
        #1;
        check_reset_outputs("midreset");
        PacketReady = 1'b0;
        expQ.delete();
        pktCnt = 0;
        fltCnt = 0;
        drpCnt = 0;
        repeat (2) @(negedge SysClock);
        ResetN = 1'b1;
        repeat (3) begin
            @(negedge SysClock);
            chk("no_readena_after_reset", ReadEna, 0);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: no finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int size;
        bit fault, good;
        ResetN = 1'b0;
        Enable = 1'b0;
        PacketReady = 1'b0;
        PacketFault = 1'b0;
        PacketSize = '0;
        repeat (3) @(negedge SysClock);
        check_reset_outputs("reset");
        ResetN = 1'b1;
        Enable = 1'b1;
        @(negedge SysClock);

        run_packet(11, 1'b0, 1'b1, 0, 0);
        run_packet(11, 1'b0, 1'b1, 0, 1);
        run_packet(20, 1'b1, 1'b0, 0, 0);
        run_packet(2, 1'b0, 1'b1, 0, 0);
        run_packet(4, 1'b0, 1'b1, 0, 1);
        run_packet(4095, 1'b0, 1'b1, 0, 2);
        run_packet(11, 1'b0, 1'b1, 5, 0);
        run_packet(30, 1'b1, 1'b1, 0, 2);

        Enable = 1'b0;
        PacketSize = 12'd11;
        PacketReady = 1'b1;
        repeat (8) @(negedge SysClock);
        chk("enable_gates_start", Busy, 0);
        PacketReady = 1'b0;
        Enable = 1'b1;
        @(negedge SysClock);

        fork
            run_packet(40, 1'b0, 1'b1, 0, 2);
            begin
                repeat (6) @(negedge SysClock);
                Enable = 1'b0;
            end
        join
        Enable = 1'b1;

        reset_mid_read();
        run_packet(11, 1'b0, 1'b1, 0, 0);

        for (int k = 0; k < 20; k++) begin
            size = $urandom_range(0, 600);
            fault = ($urandom_range(0, 3) == 0);
            good = fault ? 1'($urandom_range(0, 1)) : 1'b1;
            run_packet(size, fault, good, $urandom_range(0, 3), $urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end

endmodule
